// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter and its memory model.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 32;

    // Owner of the single outstanding memory access; doubles as the response FSM state.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating up-counter with synchronous clear, used both for fetch starvation
// tracking and for the conflict-cycle statistic.
module mem_arb_starve_cnt #(
    parameter int         W   = 3,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == MAX);

    // Clear wins over increment; the count sticks once it reaches MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, 1-cycle-latency memory between instruction
// fetch and load/store data. Data has priority, but after STARVE_MAX data
// grants in a row with fetch waiting, fetch is forced through. Responses are
// routed back to whichever port owned the previous cycle's access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    // Starvation counter only needs to reach STARVE_MAX; keep it at least one bit wide.
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    owner_e        state;
    owner_e        next_state;
    logic          resp_we;
    logic [SW-1:0] starve_cnt;
    logic          starve_at_max;
    logic          fetch_wins;
    logic          both_req;
    logic          conflict_full;

    assign both_req   = if_req_i & d_req_i;
    assign fetch_wins = (starve_cnt == SW'(STARVE_MAX));

    // Grants are gated by reset so nothing is issued while the core is held in reset.
    assign d_gnt_o   = reset_i & d_req_i & ~(if_req_i & fetch_wins);
    assign if_gnt_o  = reset_i & if_req_i & ~d_gnt_o;
    assign mem_req_o = if_gnt_o | d_gnt_o;
    assign stall_o   = reset_i & if_req_i & ~if_gnt_o;

    mem_arb_starve_cnt #(
        .W   (SW),
        .MAX (SW'(STARVE_MAX))
    ) u_starve_cnt (
        .clk    (clk_i),
        .rst_n  (reset_i),
        .inc    (d_gnt_o & if_req_i & ~starve_at_max),
        .clr    (if_gnt_o | ~if_req_i),
        .count  (starve_cnt),
        .at_max (starve_at_max)
    );

    mem_arb_starve_cnt #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_conflict_cnt (
        .clk    (clk_i),
        .rst_n  (reset_i),
        .inc    (both_req & ~conflict_full),
        .clr    (1'b0),
        .count  (conflict_cnt_o),
        .at_max (conflict_full)
    );

    // Steer the granted port's request fields onto the memory bus.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt_o) begin
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt_o) begin
            mem_be_o   = 4'hF;
            mem_addr_o = if_addr_i;
        end
    end

    // Remember who owns the in-flight access and whether a data access was a store.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= OWN_NONE;
            resp_we <= 1'b0;
        end else begin
            state <= next_state;
            if (d_gnt_o) begin
                resp_we <= d_we_i;
            end
        end
    end

    // Next owner follows this cycle's grant; responses come from the current owner.
    always_comb begin
        next_state  = OWN_NONE;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (if_gnt_o) begin
            next_state = OWN_IF;
        end else if (d_gnt_o) begin
            next_state = OWN_D;
        end
        unique case (state)
            OWN_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
            OWN_D: begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = resp_we ? '0 : mem_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-ported, 1-cycle-latency synchronous unified memory between the instruction-fetch port and the load/store data port of the core.
- Lets the core fetch and execute out of one memory array in place of separate instr_mem and data_mem.
- Grants data accesses by priority. A starvation counter bounds how long fetch waits.
- Routes read responses back to the owner of each access and raises stall_o while fetch is blocked.

Parameters:
- ADDR_W, 14, word-address width; PC>>2 indexing.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced through.
- CNT_W, 16, width of the conflict-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch word address.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DATA_W  fetch data.
- d_req_i  in  1  data request; held with its attributes until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_be_i  in  4  byte enables for stores.
- d_addr_i  in  ADDR_W  data word address.
- d_wdata_i  in  DATA_W  store data.
- d_gnt_o  out  1  data accepted this cycle.
- d_rvalid_o  out  1  response for loads and stores.
- d_rdata_o  out  DATA_W  load data; 0 for stores.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_req_o.
- stall_o  out  1  if_req_i high and if_gnt_o low.
- conflict_cnt_o  out  CNT_W  count of cycles with both requests high; saturating.

Behaviour:
- **Reset (reset_i low, asynchronous):**
  - Response FSM goes to IDLE; starve_cnt = 0; conflict_cnt_o = 0.
  - All gnt, rvalid, rdata, mem_* and stall_o outputs read 0.
  - While reset_i is low, grants are suppressed even if requests are high.
- **Grant logic (combinational, same cycle as request):**
  - Only data requests: d_gnt_o = 1.
  - Only fetch requests: if_gnt_o = 1.
  - Both requesting and starve_cnt < STARVE_MAX: data wins.
  - Both requesting and starve_cnt == STARVE_MAX: fetch wins.
  - At most one grant per cycle.
  - mem_req_o = if_gnt_o | d_gnt_o.
  - mem_* fields come from the granted port. For fetch: mem_we_o = 0, mem_be_o = 4'hF.
- **Starvation counter:**
  - Increments on each cycle with d_gnt_o & if_req_i, saturating at STARVE_MAX.
  - Clears on if_gnt_o or when if_req_i is low.
- **Response FSM (registered owner of the single outstanding access):**
  - States: IDLE, RESP_IF, RESP_D.
  - Next state is RESP_IF on if_gnt_o, RESP_D on d_gnt_o, else IDLE. This holds from any state, so back-to-back grants give one access per cycle.
  - In RESP_IF: if_rvalid_o = 1, if_rdata_o = mem_rdata_i.
  - In RESP_D: d_rvalid_o = 1. d_rdata_o = mem_rdata_i for a load, 0 for a store (registered we flag).
  - Outside the matching state, rvalid = 0 and rdata = 0.
  - Latency: grant in cycle N → rvalid in cycle N+1.
- **stall_o** is combinational and asserted in the same cycle as the lost fetch arbitration.
- **conflict_cnt_o** increments on every cycle with if_req_i & d_req_i and saturates at all-ones; it never wraps.
- **Boundary cases:**
  - Request dropped before grant: allowed; nothing is issued.
  - Reset mid-access: the pending response is discarded and no rvalid appears after reset release.
  - Simultaneous grant and response in one cycle is the normal pipelined case.
  - STARVE_MAX = 0: fetch always wins conflicts.

Decomposition:
- **Package mem_arb_pkg:**
  - owner_e enum {OWN_NONE, OWN_IF, OWN_D}, used as the FSM state.
  - Constants MEM_ADDR_W = 14 and MEM_DATA_W = 32, shared with the memory model.
- **Sub-module mem_arb_starve_cnt:**
  - Saturating counter with inc/clr inputs and an at_max output.
  - Instantiated once for starvation tracking; reusable for conflict_cnt_o with parameterised width.

Test Plan:
1. Fetch only: if_req_i = 1, if_addr_i = 0x004, memory[4] = 0x00500093 → if_gnt_o = 1 in cycle N; if_rvalid_o = 1 with if_rdata_o = 0x00500093 in N+1; stall_o = 0.
2. Store then load: d_req_i = 1, d_we_i = 1, d_be_i = 4'hF, d_addr_i = 0x010, d_wdata_i = 0xDEADBEEF, then a load from 0x010 → d_rvalid_o with d_rdata_o = 0 in the store's N+1; the load returns 0xDEADBEEF one cycle after its grant.
3. Sustained conflict, STARVE_MAX = 4, both requests high for 6 cycles → d_gnt_o in cycles 0–3, if_gnt_o in cycle 4, d_gnt_o in cycle 5; stall_o = 1 in cycles 0–3 and 5; conflict_cnt_o = 6.
4. Back-to-back fetches 0x000, 0x001, 0x002 with no data traffic → three grants in consecutive cycles; if_rvalid_o high for three consecutive cycles with matching data.
5. Reset pulse: d_gnt_o in cycle N, reset_i low mid-cycle N → d_rvalid_o never asserts; all outputs 0 during reset; FSM IDLE and counters 0 after release.
6. Saturation: force 65,540 conflict cycles → conflict_cnt_o holds 0xFFFF.
